// File: rtl/regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_arbiter
// Brief    : Two-requester round-robin access controller for a single-port
//            register file. Grants are combinational. A registered issue
//            stage drives the file pins. Read data returns two cycles after
//            the grant. Optional post-reset clear sweep is enabled by the
//            macro REGFILE_ARB_INIT_EN.
// Revision : 1.0  initial release
// ============================================================================
module regfile_arbiter #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ready,
  output logic [ADDR_W-1:0] rf_address,
  output logic [DATA_W-1:0] rf_in_data,
  output logic              rf_wr,
  output logic              rf_rd,
  input  logic [DATA_W-1:0] rf_out_data
);

  localparam logic [0:0] ST_RUN = 1'b1;
`ifdef REGFILE_ARB_INIT_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  logic [ADDR_W-1:0] r_cnt;
`endif

  logic [0:0]        r_state;
  logic              r_ptr;        // 0: requester 0 favoured, 1: requester 1
  logic              r_iss_wr;
  logic              r_iss_rd;
  logic              r_iss_id;
  logic [ADDR_W-1:0] r_iss_addr;
  logic [DATA_W-1:0] r_iss_data;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              w_run;
  logic              w_gnt0;
  logic              w_gnt1;

  // Grants only in RUN and never while reset is being applied.
  assign w_run  = (r_state == ST_RUN) && !reset;
  assign w_gnt0 = w_run && req0 && (!req1 || !r_ptr);
  assign w_gnt1 = w_run && req1 && (!req0 || r_ptr);

  // State and sweep counter: INIT walks every address once, then RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef REGFILE_ARB_INIT_EN
      r_state <= ST_INIT;
      r_cnt   <= '0;
`else
      r_state <= ST_RUN;
`endif
    end
`ifdef REGFILE_ARB_INIT_EN
    else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (r_cnt == {ADDR_W{1'b1}}) begin
        r_state <= ST_RUN;
      end
    end
`endif
  end

  // Round-robin pointer flips after any arbitration cycle with a request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (w_run && (req0 || req1)) begin
      r_ptr <= !r_ptr;
    end
  end

  // Issue stage: one registered access per cycle straight onto the file pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_iss_wr   <= 1'b0;
      r_iss_rd   <= 1'b0;
      r_iss_id   <= 1'b0;
      r_iss_addr <= '0;
      r_iss_data <= '0;
    end
`ifdef REGFILE_ARB_INIT_EN
    else if (r_state == ST_INIT) begin
      r_iss_wr   <= 1'b1;
      r_iss_rd   <= 1'b0;
      r_iss_id   <= 1'b0;
      r_iss_addr <= r_cnt;
      r_iss_data <= '0;
    end
`endif
    else if (w_gnt0) begin
      r_iss_wr   <= we0;
      r_iss_rd   <= !we0;
      r_iss_id   <= 1'b0;
      r_iss_addr <= addr0;
      r_iss_data <= we0 ? wdata0 : '0;
    end else if (w_gnt1) begin
      r_iss_wr   <= we1;
      r_iss_rd   <= !we1;
      r_iss_id   <= 1'b1;
      r_iss_addr <= addr1;
      r_iss_data <= we1 ? wdata1 : '0;
    end else begin
      // Idle: strobes drop, address and data hold their last value.
      r_iss_wr <= 1'b0;
      r_iss_rd <= 1'b0;
    end
  end

  // Read return: capture file output during the issue cycle, strobe next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= r_iss_rd && !r_iss_id;
      r_rvalid1 <= r_iss_rd && r_iss_id;
      if (r_iss_rd && !r_iss_id) begin
        r_rdata0 <= rf_out_data;
      end
      if (r_iss_rd && r_iss_id) begin
        r_rdata1 <= rf_out_data;
      end
    end
  end

  // Strobes are masked during reset so an in-flight access is discarded.
  assign gnt0       = w_gnt0;
  assign gnt1       = w_gnt1;
  assign ready      = w_run;
  assign rvalid0    = r_rvalid0 && !reset;
  assign rvalid1    = r_rvalid1 && !reset;
  assign rdata0     = r_rdata0;
  assign rdata1     = r_rdata1;
  assign rf_address = r_iss_addr;
  assign rf_in_data = r_iss_data;
  assign rf_wr      = r_iss_wr && !reset;
  assign rf_rd      = r_iss_rd && !reset;

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_arbiter
// Brief    : Self-checking bench for regfile_arbiter with a behavioural
//            register file and a transaction-level reference model.
//            Sweep checks are built when REGFILE_ARB_INIT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0]  addr0 = '0, addr1 = '0;
  logic [19:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, ready, rf_wr, rf_rd;
  logic [19:0] rdata0, rdata1, rf_in_data, rf_out_data;
  logic [3:0]  rf_address;

  logic [19:0] mem [16];
  int errors = 0;
  int checks = 0;

  regfile_arbiter #(.DATA_W(20), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .ready(ready),
    .rf_address(rf_address), .rf_in_data(rf_in_data),
    .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_out_data(rf_out_data)
  );

  always #5 clk = ~clk;

  // Behavioural single-port register file: sync write, async read.
  assign rf_out_data = mem[rf_address];
  always @(posedge clk) if (rf_wr) mem[rf_address] <= rf_in_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 40 && !ready; i++) tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: ready=%b required 1 within 40 cycles", ready);
    end
  endtask

  task automatic test_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd2; wdata0 = 20'h12345;
    reset = 1'b1;
    tick();
    tick();
    #1;
    checks += 9;
    if (gnt0 !== 1'b0)        begin errors++; $display("FAIL rst_gnt0: got %b need 0", gnt0); end
    if (gnt1 !== 1'b0)        begin errors++; $display("FAIL rst_gnt1: got %b need 0", gnt1); end
    if (ready !== 1'b0)       begin errors++; $display("FAIL rst_ready: got %b need 0", ready); end
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b need 00", rvalid0, rvalid1); end
    if (rf_wr !== 1'b0)       begin errors++; $display("FAIL rst_rf_wr: got %b need 0", rf_wr); end
    if (rf_rd !== 1'b0)       begin errors++; $display("FAIL rst_rf_rd: got %b need 0", rf_rd); end
    if (rdata0 !== 20'h0 || rdata1 !== 20'h0) begin errors++; $display("FAIL rst_rdata: got %h %h need 0 0", rdata0, rdata1); end
    if (rf_address !== 4'h0)  begin errors++; $display("FAIL rst_rf_address: got %h need 0", rf_address); end
    if (rf_in_data !== 20'h0) begin errors++; $display("FAIL rst_rf_in_data: got %h need 0", rf_in_data); end
    req0 = 1'b0; we0 = 1'b0;
  endtask

`ifdef REGFILE_ARB_INIT_EN
  task automatic test_sweep();
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd9;
    #1;
    checks += 2;
    if (ready !== 1'b0) begin errors++; $display("FAIL sweep_R_ready: got %b need 0", ready); end
    if (gnt0 !== 1'b0)  begin errors++; $display("FAIL sweep_R_gnt0: got %b need 0", gnt0); end
    for (int k = 0; k < 16; k++) begin
      tick();
      checks += 4;
      if (rf_wr !== 1'b1 || rf_address !== 4'(k)) begin
        errors++; $display("FAIL sweep_write k=%0d: wr=%b addr=%h need wr=1 addr=%h", k, rf_wr, rf_address, k);
      end
      if (rf_in_data !== 20'h0) begin errors++; $display("FAIL sweep_data k=%0d: got %h need 0", k, rf_in_data); end
      if (ready !== (k == 15)) begin errors++; $display("FAIL sweep_ready k=%0d: got %b need %b", k, ready, k == 15); end
      if (gnt0 !== (k == 15))  begin errors++; $display("FAIL sweep_gnt0 k=%0d: got %b need %b", k, gnt0, k == 15); end
    end
    tick();
    req0 = 1'b0;
    checks++;
    if (rf_rd !== 1'b1 || rf_address !== 4'd9) begin
      errors++; $display("FAIL sweep_read_issue: rd=%b addr=%h need rd=1 addr=9", rf_rd, rf_address);
    end
    tick();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 20'h0) begin
      errors++; $display("FAIL sweep_read_return: rvalid0=%b rdata0=%h need 1 00000", rvalid0, rdata0);
    end
    tick();
  endtask
`else
  task automatic test_no_init();
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = 20'h5A5A5;
    #1;
    checks += 2;
    if (ready !== 1'b1) begin errors++; $display("FAIL noinit_ready: got %b need 1", ready); end
    if (gnt0 !== 1'b1)  begin errors++; $display("FAIL noinit_gnt0: got %b need 1", gnt0); end
    tick();
    req0 = 1'b0;
    checks++;
    if (rf_wr !== 1'b1 || rf_address !== 4'd5 || rf_in_data !== 20'h5A5A5) begin
      errors++; $display("FAIL noinit_issue: wr=%b addr=%h data=%h need 1 5 5a5a5", rf_wr, rf_address, rf_in_data);
    end
    tick();
  endtask
`endif

  task automatic test_write_read();
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd3; wdata1 = 20'hABCDE;
    #1;
    checks++;
    if (gnt1 !== 1'b1) begin errors++; $display("FAIL wr_gnt1: got %b need 1", gnt1); end
    tick();
    we1 = 1'b0;
    #1;
    checks += 2;
    if (gnt1 !== 1'b1) begin errors++; $display("FAIL rd_gnt1: got %b need 1", gnt1); end
    if (rf_wr !== 1'b1 || rf_rd !== 1'b0 || rf_address !== 4'd3 || rf_in_data !== 20'hABCDE) begin
      errors++; $display("FAIL wr_issue: wr=%b rd=%b addr=%h data=%h need 1 0 3 abcde", rf_wr, rf_rd, rf_address, rf_in_data);
    end
    tick();
    req1 = 1'b0;
    checks++;
    if (rf_rd !== 1'b1 || rf_wr !== 1'b0 || rf_address !== 4'd3 || rf_in_data !== 20'h0) begin
      errors++; $display("FAIL rd_issue: wr=%b rd=%b addr=%h data=%h need 0 1 3 0", rf_wr, rf_rd, rf_address, rf_in_data);
    end
    tick();
    checks += 2;
    if (rvalid1 !== 1'b1 || rdata1 !== 20'hABCDE) begin
      errors++; $display("FAIL rd_return1: rvalid1=%b rdata1=%h need 1 abcde", rvalid1, rdata1);
    end
    if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rd_return0: rvalid0=%b need 0", rvalid0); end
    tick();
  endtask

  task automatic test_alternate();
    do_reset();
    wait_ready();
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks += 2;
      if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
        errors++; $display("FAIL alt_grant i=%0d: gnt0=%b gnt1=%b need %b %b", i, gnt0, gnt1, i % 2 == 0, i % 2 == 1);
      end
      if (gnt0 && gnt1) begin errors++; $display("FAIL alt_exclusive i=%0d: both grants high", i); end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      req0   = (i < 8);
      we0    = (i < 4);
      addr0  = (i < 4) ? 4'(i + 1) : 4'(i - 3);
      wdata0 = 20'(32'h11111 * (i + 1));
      #1;
      checks += 3;
      if (gnt0 !== (i < 8)) begin errors++; $display("FAIL b2b_gnt0 i=%0d: got %b need %b", i, gnt0, i < 8); end
      if (rvalid0 !== (i >= 6)) begin errors++; $display("FAIL b2b_rvalid0 i=%0d: got %b need %b", i, rvalid0, i >= 6); end
      if (rvalid1 !== 1'b0) begin errors++; $display("FAIL b2b_rvalid1 i=%0d: got %b need 0", i, rvalid1); end
      if (i >= 6) begin
        checks++;
        if (rdata0 !== 20'(32'h11111 * (i - 5))) begin
          errors++; $display("FAIL b2b_rdata0 i=%0d: got %h need %h", i, rdata0, 20'(32'h11111 * (i - 5)));
        end
      end
      tick();
    end
    req0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd7; wdata0 = 20'h77777;
    tick();
    we0 = 1'b0;
    #1;
    checks++;
    if (gnt0 !== 1'b1) begin errors++; $display("FAIL mid_gnt0: got %b need 1", gnt0); end
    tick();
    req0 = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (rf_wr !== 1'b0 || rvalid0 !== 1'b0) begin
      errors++; $display("FAIL mid_reset_cycle: rf_wr=%b rvalid0=%b need 0 0", rf_wr, rvalid0);
    end
    tick();
    reset = 1'b0;
    #1;
    checks += 2;
    if (rvalid0 !== 1'b0 || rdata0 !== 20'h0 || rf_rd !== 1'b0) begin
      errors++; $display("FAIL mid_discard: rvalid0=%b rdata0=%h rf_rd=%b need 0 0 0", rvalid0, rdata0, rf_rd);
    end
    if (rf_address !== 4'h0 || rf_in_data !== 20'h0) begin
      errors++; $display("FAIL mid_pins: addr=%h data=%h need 0 0", rf_address, rf_in_data);
    end
`ifdef REGFILE_ARB_INIT_EN
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b need 0", ready); end
    tick();
    checks++;
    if (rf_wr !== 1'b1 || rf_address !== 4'h0) begin
      errors++; $display("FAIL mid_sweep_restart: wr=%b addr=%h need 1 0", rf_wr, rf_address);
    end
`else
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b need 1", ready); end
`endif
  endtask

  // Randomized traffic against a transaction-level model of the controller.
  task automatic test_random();
    logic [19:0] ref_mem [16];
    logic        p_v [2];
    logic        p_we [2];
    logic [3:0]  p_addr [2];
    logic [19:0] p_data [2];
    logic [19:0] hold [2];
    int          fav;
    logic        e_g [2];
    logic        iss_v, iss_we, iss_id;
    logic [3:0]  iss_addr;
    logic [19:0] iss_data;
    logic        ret_v, ret_id;
    wait_ready();
    tick();
    for (int a = 0; a < 16; a++) ref_mem[a] = mem[a];
    fav = 0; iss_v = 0; iss_we = 0; iss_id = 0; iss_addr = '0; iss_data = '0;
    ret_v = 0; ret_id = 0;
    for (int r = 0; r < 2; r++) begin
      p_v[r] = 0; p_we[r] = 0; p_addr[r] = '0; p_data[r] = '0; hold[r] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (!p_v[r] && ($urandom % 3 != 0)) begin
          p_v[r] = 1; p_we[r] = 1'($urandom); p_addr[r] = 4'($urandom % 6);
          p_data[r] = 20'($urandom);
        end
      end
      req0 = p_v[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_data[0];
      req1 = p_v[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_data[1];
      #1;
      e_g[0] = p_v[0] && (!p_v[1] || fav == 0);
      e_g[1] = p_v[1] && (!p_v[0] || fav == 1);
      checks += 6;
      if (gnt0 !== e_g[0] || gnt1 !== e_g[1]) begin
        errors++; $display("FAIL rnd_gnt c=%0d: got %b%b need %b%b", cyc, gnt0, gnt1, e_g[0], e_g[1]);
      end
      if (rf_wr !== (iss_v && iss_we) || rf_rd !== (iss_v && !iss_we)) begin
        errors++; $display("FAIL rnd_strobe c=%0d: wr=%b rd=%b need %b %b", cyc, rf_wr, rf_rd, iss_v && iss_we, iss_v && !iss_we);
      end
      if (rf_address !== iss_addr) begin
        errors++; $display("FAIL rnd_addr c=%0d: got %h need %h", cyc, rf_address, iss_addr);
      end
      if (iss_v && rf_in_data !== (iss_we ? iss_data : 20'h0)) begin
        errors++; $display("FAIL rnd_in_data c=%0d: got %h need %h", cyc, rf_in_data, iss_we ? iss_data : 20'h0);
      end
      if (rvalid0 !== (ret_v && !ret_id) || rvalid1 !== (ret_v && ret_id)) begin
        errors++; $display("FAIL rnd_rvalid c=%0d: got %b%b need %b%b", cyc, rvalid0, rvalid1, ret_v && !ret_id, ret_v && ret_id);
      end
      if (rdata0 !== hold[0] || rdata1 !== hold[1]) begin
        errors++; $display("FAIL rnd_rdata c=%0d: got %h %h need %h %h", cyc, rdata0, rdata1, hold[0], hold[1]);
      end
      // Advance the model by one cycle.
      ret_v = iss_v && !iss_we;
      ret_id = iss_id;
      if (ret_v) hold[iss_id] = ref_mem[iss_addr];
      if (iss_v && iss_we) ref_mem[iss_addr] = iss_data;
      iss_v = e_g[0] || e_g[1];
      if (iss_v) begin
        iss_id   = e_g[1];
        iss_we   = p_we[iss_id];
        iss_addr = p_addr[iss_id];
        iss_data = p_data[iss_id];
        p_v[iss_id] = 0;
      end
      if (req0 || req1) fav = 1 - fav;
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef REGFILE_ARB_INIT_EN
    test_sweep();
`else
    test_no_init();
`endif
    test_write_read();
    test_alternate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester access controller for the 16 x 20-bit single-port register file. It arbitrates read/write requests from two clients, such as instruction decode and execute write-back, onto the one file port. It drives the file's `address`, `in_data`, `wr` and `rd` pins from a registered issue stage and returns read data to the winning requester. An optional post-reset sweep clears every register-file entry, because the file itself has no reset on its contents.

## Interface
Parameters:
- `DATA_W`, 20, width of register-file words
- `ADDR_W`, 4, register-file address width; depth is 2^ADDR_W

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `req0` / `req1`  in  1  request from requester 0 / 1
- `we0` / `we1`  in  1  1 = write, 0 = read
- `addr0` / `addr1`  in  ADDR_W  target entry
- `wdata0` / `wdata1`  in  DATA_W  write data
- `gnt0` / `gnt1`  out  1  combinational accept, valid in the cycle the request is taken
- `rvalid0` / `rvalid1`  out  1  one-cycle read-data strobe
- `rdata0` / `rdata1`  out  DATA_W  read data, held until the next `rvalid` for that requester
- `ready`  out  1  arbiter is in RUN and accepting requests
- `rf_address`  out  ADDR_W  to the file's `address` pin
- `rf_in_data`  out  DATA_W  to the file's `in_data` pin
- `rf_wr` / `rf_rd`  out  1  to the file's `wr` / `rd` pins
- `rf_out_data`  in  DATA_W  from the file's `out_data` pin (combinational read)

## Operation
- FSM states:
  - INIT: clear sweep; no grants.
  - RUN: normal arbitration.
- On `reset`: state goes to INIT (or RUN without the macro), sweep counter to 0 and round-robin pointer to 0 (requester 0 favoured).
- INIT:
  - Each cycle the issue stage loads write, address = counter, data = 0.
  - The counter increments each cycle.
  - After address 2^ADDR_W-1 is loaded, the state moves to RUN.
  - `gnt*` are held 0 throughout.
- RUN arbitration:
  - If only one `req` is high, that requester is granted.
  - If both are high, the requester not favoured by the pointer loses.
  - The pointer then favours the other requester, regardless of which one won.
  - With no request, the pointer holds.
  - At most one `gnt` is high per cycle; `gnt` is never high without its `req`.
- Handshake:
  - The requester holds `req`, `we`, `addr` and `wdata` stable until it samples `gnt` high.
  - The request is consumed at that edge.
  - Keeping `req` high after the grant means a new request.
- Issue stage:
  - On grant, captures {we, addr, wdata, requester id} into registers that directly drive `rf_*`.
  - `rf_wr` = we, `rf_rd` = !we, each for exactly one cycle.
  - `rf_in_data` = 0 on reads.
- Read return: in the issue cycle, `rf_out_data` is captured into the requester's `rdata`, with `rvalid` pulsed in the following cycle.
- Writes produce no response beyond `gnt`.
- Idle cycles: `rf_wr` = `rf_rd` = 0 and `rf_address` holds its last value.
- Reset mid-operation: an in-flight issue or read return is discarded. `rvalid*` and `rf_wr` are 0 in the reset cycle, and any sweep in progress restarts from address 0.

## Timing
- Reset values: `gnt*`, `rvalid*`, `ready`, `rf_wr` and `rf_rd` are 0; `rdata*`, `rf_address` and `rf_in_data` are 0.
- Request latency:
  - Grant in cycle N.
  - `rf_*` valid in cycle N+1.
  - `rvalid` in cycle N+2.
- Throughput is one access per cycle; back-to-back grants to the same requester are allowed when the other requester is idle.
- With the sweep enabled, let R be the first cycle with `reset` low:
  - Entry k is written in cycle R+1+k.
  - `ready` rises in cycle R+2^ADDR_W.
  - The first grant is possible in that same cycle.
- A read granted in the cycle right after a write grant to the same address returns the new data. The write is committed before the read's issue cycle.

## Configuration
- `REGFILE_ARB_INIT_EN`:
  - Defined: INIT sweep as above; `ready` rises 2^ADDR_W cycles after reset release.
  - Undefined: reset goes straight to RUN, `ready` is 1 from the first cycle after reset, the register file powers up uncleared, and the sweep counter is not synthesized.

## Test plan
- Reset release with `REGFILE_ARB_INIT_EN` -> `rf_wr`=1 with `rf_address` 0..15 and `rf_in_data`=0 in cycles R+1..R+16, `ready`=1 at R+16. Then reading address 9 from requester 0 returns `rdata0`=0 with `rvalid0` two cycles after the grant.
- Requester 1 writes 0xABCDE to address 3, then reads address 3 on the next cycle -> `gnt1` both cycles; `rf_wr` then `rf_rd` on consecutive cycles; `rdata1`=0xABCDE with `rvalid1` two cycles after the read grant.
- Both `req` held high for 6 cycles, pointer starting at 0 after reset -> grants alternate 0,1,0,1,0,1, and `gnt0`&`gnt1` is never high together.
- Only `req0` high for 4 cycles, reads of addresses 1..4 preloaded with 0x11111..0x44444 -> `gnt0` in 4 consecutive cycles, `rvalid0` in 4 consecutive cycles with those values in order, `rvalid1` stays 0.
- `reset` asserted in the cycle a read is in its issue cycle -> no `rvalid` follows, all outputs return to their reset values, and the sweep restarts at address 0.
- Build without `REGFILE_ARB_INIT_EN` -> `ready`=1 in cycle R, a `req0` write in cycle R is granted in R, and `rf_wr` is asserted in R+1.
